// File: rtl/cmd_frame_decoder.sv
// Command frame decoder: parses 0xAA/0xBB/0xCC/0xDD frames into RegFile/ALU strobes and TX FIFO pushes; optional CMD_TIMEOUT_EN.
// Latency: byte -> strobe 1 cycle; RdData_Valid -> push 2 cycles; OUT_Valid -> LSB/MSB push 2/3 cycles.
// Backpressure: pushes stall while FIFO_FULL is high; RX bytes arriving mid-wait or mid-push are dropped.
module cmd_frame_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
`ifdef CMD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  input  logic                    FIFO_FULL,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_GATE_EN,
  output logic                    WR_INC,
  output logic [DATA_WIDTH-1:0]   WR_DATA
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_RD_TX,
    S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_TX_LSB, S_TX_MSB
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

  state_t                  state_q, state_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic                    alu_en_q, alu_en_d;
  logic                    clk_gate_en_q, clk_gate_en_d;
  logic                    wr_inc_q, wr_inc_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0]   rd_byte_q, rd_byte_d;
  logic [2*DATA_WIDTH-1:0] alu_res_q, alu_res_d;
  logic                    tmo_hit;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          in_frame;

  // Only the byte-collecting states time out; wait/push states depend on RegFile/ALU/FIFO.
  always_comb begin
    in_frame  = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) || (state_q == S_RD_ADDR) ||
                (state_q == S_ALU_A)   || (state_q == S_ALU_B)   || (state_q == S_ALU_FUN);
    tmo_hit   = in_frame && !RX_D_VLD && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    tmo_cnt_d = (in_frame && !RX_D_VLD) ? tmo_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    wr_inc_d  = 1'b0;
    address_d = address_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    tx_data_d = tx_data_q;
    rd_byte_d = rd_byte_q;
    alu_res_d = alu_res_q;
    case (state_q)
      S_IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_WR:     state_d = S_WR_ADDR;
          CMD_RD:     state_d = S_RD_ADDR;
          CMD_ALU_OP: state_d = S_ALU_A;
          CMD_ALU_NO: state_d = S_ALU_FUN;
          default:    state_d = S_IDLE;
        endcase
      end
      S_WR_ADDR: if (RX_D_VLD) begin
        address_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d   = S_WR_DATA;
      end
      S_WR_DATA: if (RX_D_VLD) begin
        wr_en_d   = 1'b1;
        wr_data_d = RX_P_DATA;
        state_d   = S_IDLE;
      end
      S_RD_ADDR: if (RX_D_VLD) begin
        rd_en_d   = 1'b1;
        address_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: if (RdData_Valid) begin
        rd_byte_d = RdData;
        state_d   = S_RD_TX;
      end
      S_RD_TX: if (!FIFO_FULL) begin
        wr_inc_d  = 1'b1;
        tx_data_d = rd_byte_q;
        state_d   = S_IDLE;
      end
      S_ALU_A: if (RX_D_VLD) begin
        wr_en_d   = 1'b1;
        address_d = '0;
        wr_data_d = RX_P_DATA;
        state_d   = S_ALU_B;
      end
      S_ALU_B: if (RX_D_VLD) begin
        wr_en_d   = 1'b1;
        address_d = ADDR_WIDTH'(1);
        wr_data_d = RX_P_DATA;
        state_d   = S_ALU_FUN;
      end
      S_ALU_FUN: if (RX_D_VLD) begin
        alu_en_d  = 1'b1;
        alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
        state_d   = S_ALU_WAIT;
      end
      S_ALU_WAIT: if (OUT_Valid) begin
        alu_res_d = ALU_OUT;
        state_d   = S_TX_LSB;
      end
      S_TX_LSB: if (!FIFO_FULL) begin
        wr_inc_d  = 1'b1;
        tx_data_d = alu_res_q[DATA_WIDTH-1:0];
        state_d   = S_TX_MSB;
      end
      S_TX_MSB: if (!FIFO_FULL) begin
        wr_inc_d  = 1'b1;
        tx_data_d = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
    // Registered from next state so the gate tracks ALU_FUN/ALU_WAIT exactly.
    clk_gate_en_d = (state_d == S_ALU_FUN) || (state_d == S_ALU_WAIT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      alu_en_q      <= 1'b0;
      clk_gate_en_q <= 1'b0;
      wr_inc_q      <= 1'b0;
      address_q     <= '0;
      wr_data_q     <= '0;
      alu_fun_q     <= '0;
      tx_data_q     <= '0;
      rd_byte_q     <= '0;
      alu_res_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      alu_en_q      <= alu_en_d;
      clk_gate_en_q <= clk_gate_en_d;
      wr_inc_q      <= wr_inc_d;
      address_q     <= address_d;
      wr_data_q     <= wr_data_d;
      alu_fun_q     <= alu_fun_d;
      tx_data_q     <= tx_data_d;
      rd_byte_q     <= rd_byte_d;
      alu_res_q     <= alu_res_d;
    end
  end

  assign WrEn        = wr_en_q;
  assign RdEn        = rd_en_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = clk_gate_en_q;
  assign WR_INC      = wr_inc_q;
  assign Address     = address_q;
  assign WrData      = wr_data_q;
  assign ALU_FUN     = alu_fun_q;
  assign WR_DATA     = tx_data_q;

endmodule
